// File: rtl/pad_seq_pkg.sv
// rtl/pad_seq_pkg.sv - shared types and default sizes for the pad valve sequencer
package pad_seq_pkg;

  localparam int PAD_SEQ_NUM_CTRL     = 16;
  localparam int PAD_SEQ_DEPTH        = 32;
  localparam int PAD_SEQ_TIMER_W      = 16;
  localparam int PAD_SEQ_FLUSH_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DWELL,
    ST_FLUSH,
    ST_ABORT_FLUSH,
    ST_DONE
  } pad_seq_state_e;

  typedef struct packed {
    logic [PAD_SEQ_NUM_CTRL-1:0] mask;
    logic [PAD_SEQ_TIMER_W-1:0]  dwell;
    logic                        last;
  } pad_seq_step_t;

endpackage

// File: rtl/pad_seq_timer.sv
// rtl/pad_seq_timer.sv - loadable down-counter; expired while the count sits at zero
module pad_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/pad_valve_sequencer.sv
// rtl/pad_valve_sequencer.sv - timed step program driving ctrl/flush pads with automatic purge
// Optional multi-pass looping is enabled by defining PAD_SEQ_LOOP_EN.
module pad_valve_sequencer
  import pad_seq_pkg::*;
#(
  parameter int NUM_CTRL     = PAD_SEQ_NUM_CTRL,
  parameter int DEPTH        = PAD_SEQ_DEPTH,
  parameter int TIMER_W      = PAD_SEQ_TIMER_W,
  parameter int FLUSH_CYCLES = PAD_SEQ_FLUSH_CYCLES,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [NUM_CTRL-1:0] prog_mask,
  input  logic [TIMER_W-1:0]  prog_dwell,
  input  logic                prog_last,
  input  logic                start,
  input  logic                abort,
`ifdef PAD_SEQ_LOOP_EN
  input  logic [7:0]          loop_count,
`endif
  output logic [NUM_CTRL-1:0] ctrl_out,
  output logic [NUM_CTRL-1:0] flush_out,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       step_idx
);

  localparam bit               FLUSH_EN   = (FLUSH_CYCLES > 0);
  localparam logic [TIMER_W-1:0] FLUSH_LOAD = TIMER_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  pad_seq_state_e      state_q, state_d;
  logic [NUM_CTRL-1:0] ctrl_q, ctrl_d, flush_q, flush_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [AW-1:0]       step_q, step_d, last_addr_q, last_addr_d;
  logic                prog_valid_q, prog_valid_d;
`ifdef PAD_SEQ_LOOP_EN
  logic [7:0]          loops_q, loops_d;
`endif

  logic [NUM_CTRL-1:0] mask_mem  [DEPTH];
  logic [TIMER_W-1:0]  dwell_mem [DEPTH];

  logic                mem_we, at_last, finish, advance;
  logic [AW-1:0]       nxt_idx;
  logic [NUM_CTRL-1:0] nxt_mask, released;
  logic [TIMER_W-1:0]  nxt_dwell, tmr_val;
  logic                tmr_load, tmr_expired;

  // A dwell of zero still holds its mask for one cycle.
  function automatic logic [TIMER_W-1:0] dwell_load(input logic [TIMER_W-1:0] d);
    return (d == '0) ? '0 : d - TIMER_W'(1);
  endfunction

  assign mem_we  = prog_we && (state_q == ST_IDLE);
  assign at_last = (step_q == last_addr_q);
`ifdef PAD_SEQ_LOOP_EN
  assign finish  = at_last && (loops_q == 8'd0);
`else
  assign finish  = at_last;
`endif
  assign nxt_idx   = at_last ? '0 : step_q + AW'(1);
  assign nxt_mask  = finish ? '0 : mask_mem[nxt_idx];
  assign nxt_dwell = dwell_mem[nxt_idx];
  assign released  = ctrl_q & ~nxt_mask;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mask_mem[prog_addr]  <= prog_mask;
      dwell_mem[prog_addr] <= prog_dwell;
    end
  end

  pad_seq_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    flush_d      = flush_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    step_d       = step_q;
    last_addr_d  = last_addr_q;
    prog_valid_d = prog_valid_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    advance      = 1'b0;
`ifdef PAD_SEQ_LOOP_EN
    loops_d      = loops_q;
`endif
    if (abort && (state_q == ST_DWELL || state_q == ST_FLUSH)) begin
      // Every valve open or mid-purge gets flushed on the way out.
      ctrl_d = '0;
      if (FLUSH_EN) begin
        flush_d  = ctrl_q | flush_q;
        tmr_load = 1'b1;
        tmr_val  = FLUSH_LOAD;
        state_d  = ST_ABORT_FLUSH;
      end else begin
        flush_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_we && prog_last) begin
            last_addr_d  = prog_addr;
            prog_valid_d = 1'b1;
          end
          if (start && prog_valid_q) begin
            state_d  = ST_DWELL;
            ctrl_d   = mask_mem[0];
            busy_d   = 1'b1;
            step_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = dwell_load(dwell_mem[0]);
`ifdef PAD_SEQ_LOOP_EN
            loops_d  = loop_count;
`endif
          end
        end
        ST_DWELL: begin
          if (tmr_expired) begin
            if (released != '0 && FLUSH_EN) begin
              state_d  = ST_FLUSH;
              ctrl_d   = ctrl_q & nxt_mask;
              flush_d  = released;
              tmr_load = 1'b1;
              tmr_val  = FLUSH_LOAD;
            end else begin
              advance = 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (tmr_expired) begin
            advance = 1'b1;
          end
        end
        ST_ABORT_FLUSH: begin
          if (tmr_expired) begin
            flush_d = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      if (advance) begin
        flush_d = '0;
        if (finish) begin
          ctrl_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          ctrl_d   = nxt_mask;
          step_d   = nxt_idx;
          tmr_load = 1'b1;
          tmr_val  = dwell_load(nxt_dwell);
          state_d  = ST_DWELL;
`ifdef PAD_SEQ_LOOP_EN
          if (at_last) loops_d = loops_q - 8'd1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ctrl_q       <= '0;
      flush_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_q       <= '0;
      last_addr_q  <= '0;
      prog_valid_q <= 1'b0;
`ifdef PAD_SEQ_LOOP_EN
      loops_q      <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_q       <= step_d;
      last_addr_q  <= last_addr_d;
      prog_valid_q <= prog_valid_d;
`ifdef PAD_SEQ_LOOP_EN
      loops_q      <= loops_d;
`endif
    end
  end

  assign ctrl_out  = ctrl_q;
  assign flush_out = flush_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_idx  = step_q;

endmodule

// File: tb/tb_pad_valve_sequencer.sv
// tb/tb_pad_valve_sequencer.sv - self-checking bench with a step-list trace model
module tb_pad_valve_sequencer;

  localparam int NC = 8;
  localparam int DP = 32;
  localparam int TW = 16;
  localparam int FC = 4;
  localparam int AW = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic prog_we = 1'b0, prog_last = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [NC-1:0] prog_mask = '0;
  logic [TW-1:0] prog_dwell = '0;
`ifdef PAD_SEQ_LOOP_EN
  logic [7:0] loop_count = 8'd0;
`endif
  logic [NC-1:0] ctrl_out, flush_out;
  logic busy, done;
  logic [AW-1:0] step_idx;

  pad_valve_sequencer #(.NUM_CTRL(NC), .DEPTH(DP), .TIMER_W(TW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_mask(prog_mask), .prog_dwell(prog_dwell), .prog_last(prog_last),
    .start(start), .abort(abort),
`ifdef PAD_SEQ_LOOP_EN
    .loop_count(loop_count),
`endif
    .ctrl_out(ctrl_out), .flush_out(flush_out), .busy(busy), .done(done),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] c;
    logic [NC-1:0] f;
    logic          b;
    logic          d;
    logic [AW-1:0] s;
  } ent_t;

  ent_t          exp_q[$];
  ent_t          cur;
  logic [NC-1:0] act_c[$], act_f[$];
  logic          act_b[$], act_d[$];
  int            checks = 0, errors = 0;

  logic [NC-1:0] m_mask[DP];
  int            m_dwell[DP];
  int            m_last = 0;
  logic [AW-1:0] m_step = '0;

  function automatic ent_t mk(input logic [NC-1:0] c, input logic [NC-1:0] f,
                              input logic b, input logic d, input logic [AW-1:0] s);
    ent_t e;
    e.c = c; e.f = f; e.b = b; e.d = d; e.s = s;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      act_c.push_back(ctrl_out);
      act_f.push_back(flush_out);
      act_b.push_back(busy);
      act_d.push_back(done);
      checks++;
      if (ctrl_out !== cur.c || flush_out !== cur.f || busy !== cur.b ||
          done !== cur.d || step_idx !== cur.s) begin
        errors++;
        $display("FAIL trace[%0d] got ctrl=%h flush=%h busy=%b done=%b step=%0d want ctrl=%h flush=%h busy=%b done=%b step=%0d",
                 act_c.size() - 1, ctrl_out, flush_out, busy, done, step_idx,
                 cur.c, cur.f, cur.b, cur.d, cur.s);
      end
      checks++;
      if ((ctrl_out & flush_out) != '0) begin
        errors++;
        $display("FAIL overlap[%0d] got ctrl=%h flush=%h want disjoint", act_c.size() - 1, ctrl_out, flush_out);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic prog(input int addr, input logic [NC-1:0] mask, input int dwell, input bit last);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = AW'(addr); prog_mask = mask;
    prog_dwell = TW'(dwell); prog_last = last;
    @(posedge clk); #1;
    prog_we = 1'b0; prog_last = 1'b0;
    m_mask[addr] = mask;
    m_dwell[addr] = dwell;
    if (last) m_last = addr;
  endtask

  // Expand the program into one expected entry per cycle after start.
  task automatic build(input int abort_k);
    ent_t t[$];
    ent_t p;
    for (int i = 0; i <= m_last; i++) begin
      int d;
      logic [NC-1:0] nxt, rel;
      d = (m_dwell[i] == 0) ? 1 : m_dwell[i];
      repeat (d) t.push_back(mk(m_mask[i], '0, 1'b1, 1'b0, AW'(i)));
      nxt = (i == m_last) ? '0 : m_mask[i+1];
      rel = m_mask[i] & ~nxt;
      if (rel != '0) repeat (FC) t.push_back(mk(m_mask[i] & nxt, rel, 1'b1, 1'b0, AW'(i)));
    end
    t.push_back(mk('0, '0, 1'b0, 1'b1, AW'(m_last)));
    exp_q.push_back(mk('0, '0, 1'b0, 1'b0, m_step));
    if (abort_k > 0) begin
      for (int j = 0; j < abort_k; j++) exp_q.push_back(t[j]);
      p = t[abort_k-1];
      repeat (FC) exp_q.push_back(mk('0, p.c | p.f, 1'b1, 1'b0, p.s));
      exp_q.push_back(mk('0, '0, 1'b0, 1'b0, p.s));
      m_step = p.s;
    end else begin
      foreach (t[j]) exp_q.push_back(t[j]);
      exp_q.push_back(mk('0, '0, 1'b0, 1'b0, AW'(m_last)));
      m_step = AW'(m_last);
    end
  endtask

  task automatic run_prog(input int abort_k, input bit we_busy);
    @(posedge clk); #1;
    act_c.delete(); act_f.delete(); act_b.delete(); act_d.delete();
    start = 1'b1;
    build(abort_k);
    @(posedge clk); #1;
    start = 1'b0;
    if (we_busy) begin
      prog_we = 1'b1; prog_addr = AW'(1); prog_mask = 8'hFF; prog_dwell = TW'(1); prog_last = 1'b1;
      @(posedge clk); #1;
      prog_we = 1'b0; prog_last = 1'b0;
    end
    if (abort_k > 0) begin
      repeat (abort_k - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
    end
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", ctrl_out, 0);
    chk("reset_flush", flush_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_step", step_idx, 0);
    rst_n = 1'b1;

    // start with no program loaded
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("noprog_busy", busy, 0);
      chk("noprog_ctrl", ctrl_out, 0);
    end

    // two steps with a partial release between them
    prog(0, 8'h03, 5, 1'b0);
    prog(1, 8'h06, 3, 1'b1);
    run_prog(0, 1'b0);
    chk("t2_c1", act_c[1], 8'h03);
    chk("t2_c5", act_c[5], 8'h03);
    chk("t2_c6", act_c[6], 8'h02);
    chk("t2_f9", act_f[9], 8'h01);
    chk("t2_c10", act_c[10], 8'h06);
    chk("t2_f13", act_f[13], 8'h06);
    chk("t2_f16", act_f[16], 8'h06);
    chk("t2_d17", act_d[17], 1'b1);

    // superset mask: no purge between steps
    prog(0, 8'h01, 2, 1'b0);
    prog(1, 8'h03, 2, 1'b1);
    run_prog(0, 1'b0);
    chk("t3_c2", act_c[2], 8'h01);
    chk("t3_c3", act_c[3], 8'h03);
    chk("t3_f3", act_f[3], 8'h00);
    chk("t3_f5", act_f[5], 8'h03);
    chk("t3_f8", act_f[8], 8'h03);
    chk("t3_d9", act_d[9], 1'b1);

    // zero dwell holds the mask for exactly one cycle
    prog(0, 8'h05, 0, 1'b0);
    prog(1, 8'h0A, 1, 1'b1);
    run_prog(0, 1'b0);
    chk("dw0_c1", act_c[1], 8'h05);
    chk("dw0_c2", act_c[2], 8'h00);
    chk("dw0_f2", act_f[2], 8'h05);
    chk("dw0_c6", act_c[6], 8'h0A);
    chk("dw0_d11", act_d[11], 1'b1);

    // abort sampled at the end of cycle 3 of a long dwell
    prog(0, 8'h0F, 8, 1'b1);
    run_prog(3, 1'b0);
    chk("ab_c3", act_c[3], 8'h0F);
    chk("ab_c4", act_c[4], 8'h00);
    chk("ab_f4", act_f[4], 8'h0F);
    chk("ab_f7", act_f[7], 8'h0F);
    chk("ab_f8", act_f[8], 8'h00);
    chk("ab_b8", act_b[8], 1'b0);

    // writes while busy are dropped
    prog(0, 8'h05, 3, 1'b1);
    run_prog(0, 1'b1);
    run_prog(0, 1'b0);
    chk("wb_c3", act_c[3], 8'h05);
    chk("wb_d8", act_d[8], 1'b1);

    // asynchronous reset in the middle of a dwell
    prog(0, 8'h0F, 10, 1'b1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pre_ctrl", ctrl_out, 8'h0F);
    rst_n = 1'b0;
    #1;
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_flush", flush_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    m_step = '0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_restart_busy", busy, 0);
      chk("rst_restart_ctrl", ctrl_out, 0);
    end
    prog(0, 8'h0F, 2, 1'b1);
    run_prog(0, 1'b0);
    chk("rst_rerun_c1", act_c[1], 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
